mux_nx1_pipe: RTL and testbench
===============================

MUX_NX1_PIPE -- requirements
Module: mux_nx1_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width per input.
REQ-002 The block SHALL have parameter N, default 4, meaning input count (legal range 2..16).
REQ-003 The block SHALL derive localparam SEL_W = max(1, ceil(log2(N))); SEL_W is not overridable.
REQ-004 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_data, input, N*WIDTH bits: packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port in_sel, input, SEL_W bits: index of the input to forward.
REQ-008 Port in_valid, input, 1 bit: in_data and in_sel are valid this cycle.
REQ-009 Port in_ready, output, 1 bit: the block accepts input this cycle.
REQ-010 Port flush, input, 1 bit: synchronous discard of the held output.
REQ-011 Port out_data, output, WIDTH bits: registered selected data.
REQ-012 Port out_sel, output, SEL_W bits: registered copy of the accepted in_sel.
REQ-013 Port out_valid, output, 1 bit: out_data and out_sel hold a valid beat.
REQ-014 Port out_ready, input, 1 bit: downstream consumes the beat this cycle.

Function
REQ-015 A transfer in SHALL occur on a rising edge when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-016 in_ready SHALL equal (!out_valid || out_ready) && !flush, combinationally.
REQ-017 On a transfer in, the block SHALL load out_data with input in_sel, load out_sel with in_sel and set out_valid, giving 1-cycle latency.
REQ-018 With out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold stable, regardless of in_data, in_sel and in_valid.
REQ-019 A simultaneous transfer out and transfer in SHALL replace the held beat with the new beat, keeping out_valid=1 and leaving no bubble.
REQ-020 A transfer out with no transfer in SHALL clear out_valid on the same edge; out_data SHALL keep its last value.
REQ-021 flush=1 SHALL clear out_valid on the next edge, block acceptance that cycle, and take priority over both transfer in and transfer out.
REQ-022 The block SHALL have exactly two states, EMPTY (out_valid=0) and FULL (out_valid=1):
- EMPTY->FULL on transfer in.
- FULL->EMPTY on transfer out without transfer in, or on flush.
- Every other case holds the current state.
REQ-023 in_sel >= N is out of range; its handling SHALL be as defined under Configuration.
REQ-024 The block SHALL have no combinational path from in_data or in_sel to any output.

Reset
REQ-025 While rst_n=0, the block SHALL force out_valid=0, out_data=0 and out_sel=0 asynchronously.
REQ-026 Reset asserted mid-transfer SHALL discard the held beat; after deassertion the block SHALL be EMPTY with in_ready=1.
REQ-027 Reset deassertion SHALL be sampled synchronously; the first transfer in SHALL be possible on the first rising edge with rst_n=1.

Configuration
REQ-028 With macro MUX_NX1_PIPE_SEL_ERR_EN defined, the block SHALL add port sel_err (output, 1 bit, reset 0); sel_err SHALL be a sticky flag set by a transfer in with in_sel >= N and cleared only by reset or flush.
REQ-029 With MUX_NX1_PIPE_SEL_ERR_EN defined, an out-of-range transfer in SHALL load out_data=0 and still set out_valid.
REQ-030 Without MUX_NX1_PIPE_SEL_ERR_EN, port sel_err SHALL be absent and an out-of-range in_sel SHALL select input 0.

Verification
REQ-031 Basic select: WIDTH=32, N=4, inputs 0x11111111/0x22222222/0x33333333/0x44444444, in_sel=2, in_valid=1, out_ready=1 -> next edge out_data=0x33333333, out_sel=2, out_valid=1.
REQ-032 Backpressure: FULL holding 0x22222222 (sel 1), out_ready=0, new beat sel=3 offered for 5 cycles -> in_ready=0, out_data stays 0x22222222; then out_ready=1 -> edge 1 drains it, edge 2 shows 0x44444444.
REQ-033 Streaming: in_valid=1 and out_ready=1 for 8 cycles, in_sel cycling 0..3 -> out_valid stays 1 with no bubbles, data in order, one beat per cycle.
REQ-034 Flush: FULL, flush=1 with in_valid=1 and out_ready=1 -> in_ready=0 that cycle, next edge out_valid=0, offered beat not captured.
REQ-035 Reset mid-operation: FULL with 0x44444444, rst_n pulled low between edges -> out_valid=0, out_data=0 immediately; after release in_ready=1.
REQ-036 Out-of-range: N=3, in_sel=3 -> with macro defined, out_data=0, out_valid=1, sel_err=1 until flush; without the macro, out_data=input 0.

Source files
------------

// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-to-1 word mux with a single registered output stage and valid/ready handshake.
// Optional MUX_NX1_PIPE_SEL_ERR_EN: out-of-range selects give zero data and raise a sticky sel_err.
module mux_nx1_pipe_lane #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic [WIDTH-1:0] i_word,
  input  logic [SEL_W-1:0] i_sel,
  output logic [WIDTH-1:0] o_word
);
  localparam logic [SEL_W-1:0] IDX_L = IDX[SEL_W-1:0];

  assign o_word = (i_sel == IDX_L) ? i_word : '0;
endmodule

module mux_nx1_pipe #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
  ,
  output logic               sel_err
`endif
);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(N - 1);

  logic                       w_oor;
  logic [SEL_W-1:0]           w_sel_eff;
  logic [N-1:0][WIDTH-1:0]    w_lane;
  logic [WIDTH-1:0]           w_mux;
  logic                       w_in_fire;
  logic                       w_out_fire;

  logic [WIDTH-1:0]           r_data;
  logic [SEL_W-1:0]           r_sel;
  logic                       r_valid;

  // A power-of-two N can never see an out-of-range select.
  generate
    if (N == (1 << SEL_W)) begin : g_full_range
      assign w_oor = 1'b0;
    end else begin : g_part_range
      assign w_oor = (in_sel > MAX_SEL);
    end
  endgenerate

`ifdef MUX_NX1_PIPE_SEL_ERR_EN
  // Out-of-range select matches no lane, so the OR tree yields zero.
  assign w_sel_eff = in_sel;
`else
  assign w_sel_eff = w_oor ? '0 : in_sel;
`endif

  generate
    for (genvar k = 0; k < N; k++) begin : g_lane
      mux_nx1_pipe_lane #(.WIDTH(WIDTH), .SEL_W(SEL_W), .IDX(k)) u_lane (
        .i_word (in_data[k*WIDTH +: WIDTH]),
        .i_sel  (w_sel_eff),
        .o_word (w_lane[k])
      );
    end
  endgenerate

  always_comb begin
    w_mux = '0;
    for (int k = 0; k < N; k++) w_mux = w_mux | w_lane[k];
  end

  assign in_ready   = (!r_valid || out_ready) && !flush;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_valid && out_ready;

  // Flush wins over both transfers; data is only reloaded on an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= 1'b1;
      r_data  <= w_mux;
      r_sel   <= in_sel;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
    end
  end

`ifdef MUX_NX1_PIPE_SEL_ERR_EN
  logic r_sel_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_sel_err <= 1'b0;
    else if (flush)             r_sel_err <= 1'b0;
    else if (w_in_fire && w_oor) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;
`endif

  assign out_data  = r_data;
  assign out_sel   = r_sel;
  assign out_valid = r_valid;
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: vector table plus scoreboard on an N=4 instance, hand sequences
// for reset mid-operation and out-of-range select on an N=3 instance.
module tb_mux_nx1_pipe;
  localparam int W = 32;

  typedef struct {
    logic [1:0]  sel;
    logic        v;
    logic        ordy;
    logic        fl;
    logic        exp_rdy;
    logic        exp_vld;
    logic [31:0] exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  sel;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [4*W-1:0] in_data;
  logic [1:0]     in_sel;
  logic           in_valid, in_ready, flush, out_valid, out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;

  logic [3*W-1:0] d3_in_data;
  logic [1:0]     d3_sel, d3_out_sel;
  logic           d3_valid, d3_ready, d3_flush, d3_out_valid, d3_oready;
  logic [W-1:0]   d3_out_data;
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
  logic           sel_err4, d3_sel_err;
`endif

  mux_nx1_pipe #(.WIDTH(W), .N(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .out_data(out_data), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
    , .sel_err(sel_err4)
`endif
  );

  mux_nx1_pipe #(.WIDTH(W), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_sel(d3_sel), .in_valid(d3_valid),
    .in_ready(d3_ready), .flush(d3_flush), .out_data(d3_out_data), .out_sel(d3_out_sel),
    .out_valid(d3_out_valid), .out_ready(d3_oready)
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
    , .sel_err(d3_sel_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] words [4];
  beat_t sb[$];
  logic m_valid;
  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic v, input logic ordy,
                              input logic fl, input logic rdy, input logic vld,
                              input logic [31:0] d, input logic [1:0] s);
    vec_t t;
    t.sel = sel; t.v = v; t.ordy = ordy; t.fl = fl;
    t.exp_rdy = rdy; t.exp_vld = vld; t.exp_data = d; t.exp_sel = s;
    return t;
  endfunction

  // Drive one cycle at the negedge, score it, then check registered outputs after the edge.
  task automatic apply_vec(input vec_t t, input string tag);
    logic m_rdy, fire_in, fire_out;
    beat_t b;
    in_sel = t.sel; in_valid = t.v; out_ready = t.ordy; flush = t.fl;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(t.exp_rdy));
    m_rdy    = (!m_valid || t.ordy) && !t.fl;
    fire_in  = t.v && m_rdy;
    fire_out = m_valid && t.ordy && !t.fl;
    if (fire_out) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s.sb_empty actual=pop required=beat", tag);
      end else begin
        b = sb.pop_front();
        chk({tag, ".sb_data"}, out_data, b.data);
        chk({tag, ".sb_sel"}, 32'(out_sel), 32'(b.sel));
      end
    end
    if (t.fl) sb.delete();
    if (fire_in) sb.push_back('{data: words[t.sel], sel: t.sel});
    m_valid = t.fl ? 1'b0 : fire_in ? 1'b1 : fire_out ? 1'b0 : m_valid;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(t.exp_vld));
    chk({tag, ".out_data"}, out_data, t.exp_data);
    chk({tag, ".out_sel"}, 32'(out_sel), 32'(t.exp_sel));
  endtask

  initial begin
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;

    vecs[0]  = mk(2, 1, 1, 0, 1, 1, 32'h33333333, 2);
    vecs[1]  = mk(0, 1, 1, 0, 1, 1, 32'h11111111, 0);
    vecs[2]  = mk(3, 1, 0, 0, 0, 1, 32'h11111111, 0);
    vecs[3]  = mk(1, 0, 1, 0, 1, 0, 32'h11111111, 0);
    vecs[4]  = mk(1, 1, 0, 0, 1, 1, 32'h22222222, 1);
    for (int k = 5; k < 10; k++) vecs[k] = mk(3, 1, 0, 0, 0, 1, 32'h22222222, 1);
    vecs[10] = mk(3, 0, 1, 0, 1, 0, 32'h22222222, 1);
    vecs[11] = mk(3, 1, 1, 0, 1, 1, 32'h44444444, 3);
    vecs[12] = mk(0, 1, 1, 1, 0, 0, 32'h44444444, 3);
    vecs[13] = mk(2, 1, 0, 0, 1, 1, 32'h33333333, 2);
    for (int k = 0; k < 8; k++)
      vecs[14+k] = mk(2'(k % 4), 1, 1, 0, 1, 1, 32'h11111111 * 32'(k % 4 + 1), 2'(k % 4));
    vecs[22] = mk(0, 0, 1, 0, 1, 0, 32'h44444444, 3);

    rst_n = 1'b0;
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    in_sel = 0; in_valid = 0; flush = 0; out_ready = 0;
    d3_in_data = {32'h33333333, 32'h22222222, 32'h11111111};
    d3_sel = 0; d3_valid = 0; d3_flush = 0; d3_oready = 0;
    m_valid = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", out_data, 32'd0);
    chk("rst.out_sel", 32'(out_sel), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 23; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset pulled between edges while FULL.
    apply_vec(mk(3, 1, 0, 0, 1, 1, 32'h44444444, 3), "pre_rst");
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'd0);
    chk("midrst.out_data", out_data, 32'd0);
    chk("midrst.out_sel", 32'(out_sel), 32'd0);
    m_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("postrst.in_ready", 32'(in_ready), 32'd1);
    apply_vec(mk(1, 1, 1, 0, 1, 1, 32'h22222222, 1), "postrst");

    // Out-of-range select on the N=3 instance.
    d3_sel = 3; d3_valid = 1; d3_oready = 0; d3_flush = 0;
    #1 chk("oor.in_ready", 32'(d3_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("oor.out_valid", 32'(d3_out_valid), 32'd1);
    chk("oor.out_sel", 32'(d3_out_sel), 32'd3);
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
    chk("oor.out_data", d3_out_data, 32'd0);
    chk("oor.sel_err", 32'(d3_sel_err), 32'd1);
`else
    chk("oor.out_data", d3_out_data, 32'h11111111);
`endif
    d3_sel = 1; d3_oready = 1;
    @(posedge clk); @(negedge clk);
    chk("oor2.out_data", d3_out_data, 32'h22222222);
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
    chk("oor2.sel_err", 32'(d3_sel_err), 32'd1);
`endif
    d3_valid = 0; d3_flush = 1;
    #1 chk("oorfl.in_ready", 32'(d3_ready), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("oorfl.out_valid", 32'(d3_out_valid), 32'd0);
`ifdef MUX_NX1_PIPE_SEL_ERR_EN
    chk("oorfl.sel_err", 32'(d3_sel_err), 32'd0);
`endif
    d3_flush = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
